// File: rtl/motor_reg_bank_if.sv
// Avalon-MM slave bus bundle for the motor register bank.
// The CPU side takes the master modport; the register bank takes the slave modport.
interface motor_reg_bank_if;
  logic [7:0]  avs_address;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_read;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;

  modport master (
    output avs_address, avs_write, avs_writedata, avs_read,
    input  avs_readdata, avs_readdatavalid
  );

  modport slave (
    input  avs_address, avs_write, avs_writedata, avs_read,
    output avs_readdata, avs_readdatavalid
  );
endinterface

// File: rtl/motor_reg_bank.sv
// Multi-channel register bank for the stepper motor cores.
// Motion parameters are double-buffered (shadow -> active on commit); status is sticky W1C.
module motor_reg_bank #(
  parameter int unsigned NUM_CH  = 4,
  parameter logic [31:0] VERSION = 32'h0002_0000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  motor_reg_bank_if.slave        avs,
  output logic                   irq,
  output logic [NUM_CH-1:0]      start,
  output logic [NUM_CH-1:0]      stop,
  output logic [NUM_CH-1:0]      dec,
  output logic [NUM_CH-1:0]      abs_load,
  output logic [5*NUM_CH-1:0]    move_mode,
  output logic [32*NUM_CH-1:0]   acc,
  output logic [16*NUM_CH-1:0]   start_speed,
  output logic [32*NUM_CH-1:0]   max_speed,
  output logic [32*NUM_CH-1:0]   target_speed,
  output logic [32*NUM_CH-1:0]   position_set,
  output logic [NUM_CH-1:0]      set_dir,
  output logic [NUM_CH-1:0]      opt_level,
  output logic [NUM_CH-1:0]      enable,
  output logic [32*NUM_CH-1:0]   abs_set_position,
  input  logic [32*NUM_CH-1:0]   abs_position,
  input  logic [NUM_CH-1:0]      done_in,
  input  logic [NUM_CH-1:0]      limit_in,
  input  logic [5*NUM_CH-1:0]    error_in
);

  localparam logic [4:0] OFF_CTRL   = 5'h00;
  localparam logic [4:0] OFF_MODE   = 5'h01;
  localparam logic [4:0] OFF_ACC    = 5'h02;
  localparam logic [4:0] OFF_SSPD   = 5'h03;
  localparam logic [4:0] OFF_MSPD   = 5'h04;
  localparam logic [4:0] OFF_TSPD   = 5'h05;
  localparam logic [4:0] OFF_POS    = 5'h06;
  localparam logic [4:0] OFF_CFG    = 5'h07;
  localparam logic [4:0] OFF_ABSSET = 5'h08;
  localparam logic [4:0] OFF_ABSPOS = 5'h09;
  localparam logic [4:0] OFF_STATUS = 5'h0A;
  localparam logic [4:0] OFF_IRQEN  = 5'h0B;
  localparam logic [4:0] OFF_SEL    = 5'h0C;
  localparam logic [4:0] OFF_NONE   = 5'h1F;
  localparam logic [4:0] OFF_COMMIT = 5'h00;
  localparam logic [4:0] OFF_VER    = 5'h01;
  localparam logic [4:0] OFF_PEND   = 5'h02;

  logic [NUM_CH-1:0][4:0]  mode_sh_q, mode_sh_d, mode_q, mode_d;
  logic [NUM_CH-1:0][31:0] acc_sh_q, acc_sh_d, acc_q, acc_d;
  logic [NUM_CH-1:0][15:0] sspd_sh_q, sspd_sh_d, sspd_q, sspd_d;
  logic [NUM_CH-1:0][31:0] mspd_sh_q, mspd_sh_d, mspd_q, mspd_d;
  logic [NUM_CH-1:0][31:0] tspd_sh_q, tspd_sh_d, tspd_q, tspd_d;
  logic [NUM_CH-1:0][31:0] pos_sh_q, pos_sh_d, pos_q, pos_d;
  logic [NUM_CH-1:0][31:0] abs_set_q, abs_set_d;
  logic [NUM_CH-1:0][1:0]  irq_en_q, irq_en_d;
  logic [NUM_CH-1:0]       set_dir_q, set_dir_d, opt_level_q, opt_level_d;
  logic [NUM_CH-1:0]       enable_q, enable_d, sel_q, sel_d;
  logic [NUM_CH-1:0]       start_q, start_d, stop_q, stop_d;
  logic [NUM_CH-1:0]       dec_q, dec_d, abs_load_q, abs_load_d;
  logic [NUM_CH-1:0]       done_st_q, done_st_d, err_st_q, err_st_d;
  logic                    irq_q, irq_d, rvalid_q, rvalid_d;
  logic [31:0]             rdata_q, rdata_d, rd_s;

  logic [2:0]              ch_s;
  logic [4:0]              off_s;
  logic [31:0]             wd_s;
  logic                    glob_s;
  logic [NUM_CH-1:0]       ch_hit_s, commit_s, glob_commit_s, start_commit_s;
  logic [NUM_CH-1:0]       done_clr_s, err_clr_s, err_set_s, pend_s;
  logic [NUM_CH-1:0][31:0] abs_pos_s;
  logic [NUM_CH-1:0][4:0]  err_code_s;

  assign ch_s       = avs.avs_address[7:5];
  assign off_s      = avs.avs_address[4:0];
  assign wd_s       = avs.avs_writedata;
  assign glob_s     = (ch_s == 3'd7);
  assign abs_pos_s  = abs_position;
  assign err_code_s = error_in;
  assign glob_commit_s = (avs.avs_write && glob_s && off_s == OFF_COMMIT) ?
                         wd_s[NUM_CH-1:0] : {NUM_CH{1'b0}};
  assign commit_s   = glob_commit_s | start_commit_s;

  // Channel decode and the per-cycle sticky/pending terms.
  always_comb begin
    ch_hit_s  = '0;
    err_set_s = '0;
    pend_s    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_hit_s[i]  = (ch_s == 3'(i));
      err_set_s[i] = |err_code_s[i];
      pend_s[i]    = |({err_st_q[i], done_st_q[i]} & irq_en_q[i]);
    end
    irq_d = |pend_s;
  end

  // Register writes: shadow fields, direct config, W1C strobes and command pulses.
  always_comb begin
    mode_sh_d = mode_sh_q;  acc_sh_d  = acc_sh_q;  sspd_sh_d = sspd_sh_q;
    mspd_sh_d = mspd_sh_q;  tspd_sh_d = tspd_sh_q; pos_sh_d  = pos_sh_q;
    abs_set_d = abs_set_q;  irq_en_d  = irq_en_q;  sel_d     = sel_q;
    set_dir_d = set_dir_q;  opt_level_d = opt_level_q; enable_d = enable_q;
    start_d = '0; stop_d = '0; dec_d = '0; abs_load_d = '0;
    start_commit_s = '0; done_clr_s = '0; err_clr_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      // Folding the strobe into the selector keeps non-addressed channels on the default arm.
      case ((avs.avs_write && ch_hit_s[i]) ? off_s : OFF_NONE)
        OFF_CTRL: begin
          start_d[i]        = wd_s[0];
          stop_d[i]         = wd_s[1];
          dec_d[i]          = wd_s[2];
          abs_load_d[i]     = wd_s[3];
          start_commit_s[i] = wd_s[0];
        end
        OFF_MODE:   mode_sh_d[i] = wd_s[4:0];
        OFF_ACC:    acc_sh_d[i]  = wd_s;
        OFF_SSPD:   sspd_sh_d[i] = wd_s[15:0];
        OFF_MSPD:   mspd_sh_d[i] = wd_s;
        OFF_TSPD:   tspd_sh_d[i] = wd_s;
        OFF_POS:    pos_sh_d[i]  = wd_s;
        OFF_CFG: begin
          set_dir_d[i]   = wd_s[0];
          opt_level_d[i] = wd_s[1];
          enable_d[i]    = wd_s[2];
        end
        OFF_ABSSET: abs_set_d[i] = wd_s;
        OFF_STATUS: begin
          done_clr_s[i] = wd_s[0];
          err_clr_s[i]  = wd_s[1];
        end
        OFF_IRQEN:  irq_en_d[i] = wd_s[1:0];
        OFF_SEL:    sel_d[i]    = wd_s[0];
        default:    begin end
      endcase
    end
    // Set is applied after clear so a coincident event is never lost.
    done_st_d = (done_st_q & ~done_clr_s) | done_in;
    err_st_d  = (err_st_q & ~err_clr_s) | err_set_s;
  end

  // Atomic shadow-to-active copy for every committed channel.
  always_comb begin
    mode_d = mode_q; acc_d = acc_q; sspd_d = sspd_q;
    mspd_d = mspd_q; tspd_d = tspd_q; pos_d = pos_q;
    for (int i = 0; i < NUM_CH; i++) begin
      mode_d[i] = commit_s[i] ? mode_sh_q[i] : mode_q[i];
      acc_d[i]  = commit_s[i] ? acc_sh_q[i]  : acc_q[i];
      sspd_d[i] = commit_s[i] ? sspd_sh_q[i] : sspd_q[i];
      mspd_d[i] = commit_s[i] ? mspd_sh_q[i] : mspd_q[i];
      tspd_d[i] = commit_s[i] ? tspd_sh_q[i] : tspd_q[i];
      pos_d[i]  = commit_s[i] ? pos_sh_q[i]  : pos_q[i];
    end
  end

  // Read mux built from pre-write state, so a same-cycle write is not visible yet.
  always_comb begin
    rd_s = 32'h0;
    for (int i = 0; i < NUM_CH; i++) begin
      case (ch_hit_s[i] ? off_s : OFF_NONE)
        OFF_MODE:   rd_s = {27'd0, (sel_q[i] ? mode_sh_q[i] : mode_q[i])};
        OFF_ACC:    rd_s = sel_q[i] ? acc_sh_q[i] : acc_q[i];
        OFF_SSPD:   rd_s = {16'd0, (sel_q[i] ? sspd_sh_q[i] : sspd_q[i])};
        OFF_MSPD:   rd_s = sel_q[i] ? mspd_sh_q[i] : mspd_q[i];
        OFF_TSPD:   rd_s = sel_q[i] ? tspd_sh_q[i] : tspd_q[i];
        OFF_POS:    rd_s = sel_q[i] ? pos_sh_q[i] : pos_q[i];
        OFF_CFG:    rd_s = {29'd0, enable_q[i], opt_level_q[i], set_dir_q[i]};
        OFF_ABSSET: rd_s = abs_set_q[i];
        OFF_ABSPOS: rd_s = abs_pos_s[i];
        OFF_STATUS: rd_s = {19'd0, err_code_s[i], 5'd0, limit_in[i], err_st_q[i], done_st_q[i]};
        OFF_IRQEN:  rd_s = {30'd0, irq_en_q[i]};
        OFF_SEL:    rd_s = {31'd0, sel_q[i]};
        default:    begin end
      endcase
    end
    case (glob_s ? off_s : OFF_NONE)
      OFF_VER:  rd_s = VERSION;
      OFF_PEND: rd_s = {{(32-NUM_CH){1'b0}}, pend_s};
      default:  begin end
    endcase
    rdata_d  = avs.avs_read ? rd_s : rdata_q;
    rvalid_d = avs.avs_read;
  end

  // State registers; async reset also kills pending pulses and readdatavalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_sh_q <= '0; acc_sh_q <= '0; sspd_sh_q <= '0;
      mspd_sh_q <= '0; tspd_sh_q <= '0; pos_sh_q <= '0;
      mode_q <= '0; acc_q <= '0; sspd_q <= '0;
      mspd_q <= '0; tspd_q <= '0; pos_q <= '0;
      abs_set_q <= '0; irq_en_q <= '0; sel_q <= '0;
      set_dir_q <= '0; opt_level_q <= '0; enable_q <= '0;
      start_q <= '0; stop_q <= '0; dec_q <= '0; abs_load_q <= '0;
      done_st_q <= '0; err_st_q <= '0;
      irq_q <= 1'b0; rvalid_q <= 1'b0; rdata_q <= 32'h0;
    end else begin
      mode_sh_q <= mode_sh_d; acc_sh_q <= acc_sh_d; sspd_sh_q <= sspd_sh_d;
      mspd_sh_q <= mspd_sh_d; tspd_sh_q <= tspd_sh_d; pos_sh_q <= pos_sh_d;
      mode_q <= mode_d; acc_q <= acc_d; sspd_q <= sspd_d;
      mspd_q <= mspd_d; tspd_q <= tspd_d; pos_q <= pos_d;
      abs_set_q <= abs_set_d; irq_en_q <= irq_en_d; sel_q <= sel_d;
      set_dir_q <= set_dir_d; opt_level_q <= opt_level_d; enable_q <= enable_d;
      start_q <= start_d; stop_q <= stop_d; dec_q <= dec_d; abs_load_q <= abs_load_d;
      done_st_q <= done_st_d; err_st_q <= err_st_d;
      irq_q <= irq_d; rvalid_q <= rvalid_d; rdata_q <= rdata_d;
    end
  end

  assign avs.avs_readdata      = rdata_q;
  assign avs.avs_readdatavalid = rvalid_q;
  assign irq              = irq_q;
  assign start            = start_q;
  assign stop             = stop_q;
  assign dec              = dec_q;
  assign abs_load         = abs_load_q;
  assign move_mode        = mode_q;
  assign acc              = acc_q;
  assign start_speed      = sspd_q;
  assign max_speed        = mspd_q;
  assign target_speed     = tspd_q;
  assign position_set     = pos_q;
  assign set_dir          = set_dir_q;
  assign opt_level        = opt_level_q;
  assign enable           = enable_q;
  assign abs_set_position = abs_set_q;

endmodule

// File: tb/tb_motor_reg_bank.sv
// Self-checking bench for motor_reg_bank: directed table, corner-case sequences,
// and randomized bus traffic against a register-level reference model.
module tb_motor_reg_bank;
  localparam int NCH = 4;
  localparam logic [31:0] VER = 32'h0002_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  motor_reg_bank_if bus();

  logic                irq;
  logic [NCH-1:0]      start, stop, dec, abs_load, set_dir, opt_level, enable;
  logic [5*NCH-1:0]    move_mode;
  logic [32*NCH-1:0]   acc, max_speed, target_speed, position_set, abs_set_position;
  logic [16*NCH-1:0]   start_speed;
  logic [32*NCH-1:0]   abs_position;
  logic [NCH-1:0]      done_in, limit_in;
  logic [5*NCH-1:0]    error_in;

  motor_reg_bank #(.NUM_CH(NCH), .VERSION(VER)) dut (
    .clk(clk), .rst_n(rst_n), .avs(bus), .irq(irq),
    .start(start), .stop(stop), .dec(dec), .abs_load(abs_load),
    .move_mode(move_mode), .acc(acc), .start_speed(start_speed),
    .max_speed(max_speed), .target_speed(target_speed), .position_set(position_set),
    .set_dir(set_dir), .opt_level(opt_level), .enable(enable),
    .abs_set_position(abs_set_position), .abs_position(abs_position),
    .done_in(done_in), .limit_in(limit_in), .error_in(error_in)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_op(input logic w, input logic r, input logic [7:0] a, input logic [31:0] d);
    bus.avs_write = w; bus.avs_read = r; bus.avs_address = a; bus.avs_writedata = d;
    tick();
    bus.avs_write = 1'b0; bus.avs_read = 1'b0;
  endtask

  task automatic clear_inputs;
    bus.avs_write = 1'b0; bus.avs_read = 1'b0; bus.avs_address = 8'h0; bus.avs_writedata = 32'h0;
    abs_position = '0; done_in = '0; limit_in = '0; error_in = '0;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
  endtask

  function automatic logic outs_any();
    return |{irq, start, stop, dec, abs_load, move_mode, acc, start_speed, max_speed,
             target_speed, position_set, set_dir, opt_level, enable, abs_set_position};
  endfunction

  // ---------------- reference model (register-level view) ----------------
  logic [31:0] m_sh  [NCH][7];
  logic [31:0] m_act [NCH][7];
  logic [2:0]  m_cfg [NCH];
  logic [31:0] m_abs_set [NCH];
  logic [1:0]  m_irq_en [NCH];
  logic        m_sel [NCH];
  logic        m_done [NCH];
  logic        m_err [NCH];
  logic [NCH-1:0] e_start, e_stop, e_dec, e_abs;

  task automatic m_reset;
    for (int c = 0; c < NCH; c++) begin
      for (int o = 0; o < 7; o++) begin m_sh[c][o] = 32'h0; m_act[c][o] = 32'h0; end
      m_cfg[c] = 3'd0; m_abs_set[c] = 32'h0; m_irq_en[c] = 2'd0;
      m_sel[c] = 1'b0; m_done[c] = 1'b0; m_err[c] = 1'b0;
    end
  endtask

  function automatic logic [31:0] fmask(input int o);
    if (o == 1) return 32'h0000_001F;
    else if (o == 3) return 32'h0000_FFFF;
    else return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [NCH-1:0] m_pend();
    logic [NCH-1:0] p;
    for (int c = 0; c < NCH; c++)
      p[c] = (m_done[c] && m_irq_en[c][0]) || (m_err[c] && m_irq_en[c][1]);
    return p;
  endfunction

  task automatic m_commit(input int c);
    for (int o = 1; o <= 6; o++) m_act[c][o] = m_sh[c][o];
  endtask

  function automatic logic [31:0] m_read(input logic [7:0] a);
    int c = int'(a[7:5]);
    int o = int'(a[4:0]);
    logic [31:0] r = 32'h0;
    if (c == 7) begin
      if (o == 1) r = VER;
      else if (o == 2) r = 32'(m_pend());
    end else if (c < NCH) begin
      if (o >= 1 && o <= 6) r = m_sel[c] ? m_sh[c][o] : m_act[c][o];
      else if (o == 7) r = 32'(m_cfg[c]);
      else if (o == 8) r = m_abs_set[c];
      else if (o == 9) r = abs_position[32*c +: 32];
      else if (o == 10) r = (32'(error_in[5*c +: 5]) << 8) | (32'(limit_in[c]) << 2)
                            | (32'(m_err[c]) << 1) | 32'(m_done[c]);
      else if (o == 11) r = 32'(m_irq_en[c]);
      else if (o == 12) r = 32'(m_sel[c]);
    end
    return r;
  endfunction

  task automatic m_write(input logic [7:0] a, input logic [31:0] d);
    int c = int'(a[7:5]);
    int o = int'(a[4:0]);
    if (c == 7) begin
      if (o == 0) for (int i = 0; i < NCH; i++) if (d[i]) m_commit(i);
    end else if (c < NCH) begin
      if (o == 0) begin
        e_start[c] = d[0]; e_stop[c] = d[1]; e_dec[c] = d[2]; e_abs[c] = d[3];
        if (d[0]) m_commit(c);
      end
      else if (o >= 1 && o <= 6) m_sh[c][o] = d & fmask(o);
      else if (o == 7) m_cfg[c] = d[2:0];
      else if (o == 8) m_abs_set[c] = d;
      else if (o == 10) begin
        if (d[0]) m_done[c] = 1'b0;
        if (d[1]) m_err[c] = 1'b0;
      end
      else if (o == 11) m_irq_en[c] = d[1:0];
      else if (o == 12) m_sel[c] = d[0];
    end
  endtask

  task automatic m_check_outputs(input int n);
    logic [127:0] ea, ems, ets, eps, eas, esp, emd;
    logic [NCH-1:0] ed, eo, ee;
    ea = '0; ems = '0; ets = '0; eps = '0; eas = '0; esp = '0; emd = '0;
    for (int c = 0; c < NCH; c++) begin
      emd[5*c +: 5]   = m_act[c][1][4:0];
      ea[32*c +: 32]  = m_act[c][2];
      esp[16*c +: 16] = m_act[c][3][15:0];
      ems[32*c +: 32] = m_act[c][4];
      ets[32*c +: 32] = m_act[c][5];
      eps[32*c +: 32] = m_act[c][6];
      eas[32*c +: 32] = m_abs_set[c];
      ed[c] = m_cfg[c][0]; eo[c] = m_cfg[c][1]; ee[c] = m_cfg[c][2];
    end
    chk($sformatf("rnd%0d_mode", n), move_mode, emd);
    chk($sformatf("rnd%0d_acc", n), acc, ea);
    chk($sformatf("rnd%0d_sspd", n), start_speed, esp);
    chk($sformatf("rnd%0d_mspd", n), max_speed, ems);
    chk($sformatf("rnd%0d_tspd", n), target_speed, ets);
    chk($sformatf("rnd%0d_pos", n), position_set, eps);
    chk($sformatf("rnd%0d_absset", n), abs_set_position, eas);
    chk($sformatf("rnd%0d_cfg", n), {enable, opt_level, set_dir}, {ee, eo, ed});
    chk($sformatf("rnd%0d_pulses", n), {start, stop, dec, abs_load}, {e_start, e_stop, e_dec, e_abs});
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        wr;
    logic        rd;
    logic [7:0]  addr;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [23];
  logic [NCH-1:0] pend_prev;
  logic [31:0] exp_rd, last_rd, wd;
  logic [7:0] addr;
  logic do_wr, do_rd;

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 8'h22, 32'h0000_1000, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 8'h24, 32'h0000_2000, 32'h0};
    tbl[2]  = '{1'b0, 1'b1, 8'h22, 32'h0,         32'h0};
    tbl[3]  = '{1'b1, 1'b0, 8'h2C, 32'h0000_0001, 32'h0};
    tbl[4]  = '{1'b0, 1'b1, 8'h22, 32'h0,         32'h0000_1000};
    tbl[5]  = '{1'b0, 1'b1, 8'h24, 32'h0,         32'h0000_2000};
    tbl[6]  = '{1'b1, 1'b0, 8'h2C, 32'h0,         32'h0};
    tbl[7]  = '{1'b1, 1'b0, 8'hE0, 32'h0000_0002, 32'h0};
    tbl[8]  = '{1'b0, 1'b1, 8'h22, 32'h0,         32'h0000_1000};
    tbl[9]  = '{1'b0, 1'b1, 8'h02, 32'h0,         32'h0};
    tbl[10] = '{1'b0, 1'b1, 8'h3F, 32'h0,         32'h0};
    tbl[11] = '{1'b0, 1'b1, 8'hE1, 32'h0,         VER};
    tbl[12] = '{1'b0, 1'b1, 8'hA2, 32'h0,         32'h0};
    tbl[13] = '{1'b1, 1'b0, 8'hA2, 32'hDEAD_BEEF, 32'h0};
    tbl[14] = '{1'b0, 1'b1, 8'hA2, 32'h0,         32'h0};
    tbl[15] = '{1'b1, 1'b0, 8'h23, 32'hABCD_1234, 32'h0};
    tbl[16] = '{1'b1, 1'b0, 8'h2C, 32'h0000_0001, 32'h0};
    tbl[17] = '{1'b0, 1'b1, 8'h23, 32'h0,         32'h0000_1234};
    tbl[18] = '{1'b0, 1'b1, 8'h2C, 32'h0,         32'h0000_0001};
    tbl[19] = '{1'b1, 1'b0, 8'h27, 32'hFFFF_FFFF, 32'h0};
    tbl[20] = '{1'b0, 1'b1, 8'h27, 32'h0,         32'h0000_0007};
    tbl[21] = '{1'b0, 1'b1, 8'h20, 32'h0,         32'h0};
    tbl[22] = '{1'b0, 1'b1, 8'hE0, 32'h0,         32'h0};

    clear_inputs();
    #1;
    chk("async_rst_outs", {31'd0, outs_any()}, 32'd0);
    do_reset();
    chk("rst_outs", {31'd0, outs_any()}, 32'd0);
    chk("rst_rvalid", bus.avs_readdatavalid, 1'b0);
    chk("rst_rdata", bus.avs_readdata, 32'h0);

    // Atomic commit: both active values move on the commit edge only.
    bus_op(1'b1, 1'b0, 8'h22, 32'h1000);
    bus_op(1'b1, 1'b0, 8'h24, 32'h2000);
    chk("commit_pre_acc1", acc[63:32], 32'h0);
    chk("commit_pre_ms1", max_speed[63:32], 32'h0);
    bus_op(1'b1, 1'b0, 8'hE0, 32'h2);
    chk("commit_acc1", acc[63:32], 32'h1000);
    chk("commit_ms1", max_speed[63:32], 32'h2000);
    chk("commit_acc0", acc[31:0], 32'h0);

    // Start-commit: pulse and parameters arrive together.
    bus_op(1'b1, 1'b0, 8'h45, 32'd500);
    chk("startc_pre_ts2", target_speed[95:64], 32'h0);
    bus_op(1'b1, 1'b0, 8'h40, 32'h1);
    chk("startc_pulse", start, 4'b0100);
    chk("startc_ts2", target_speed[95:64], 32'd500);
    tick();
    chk("startc_pulse_gone", start, 4'b0000);

    // Back-to-back CTRL writes give back-to-back pulses.
    bus_op(1'b1, 1'b0, 8'h00, 32'h4);
    chk("b2b_dec1", dec, 4'b0001);
    bus_op(1'b1, 1'b0, 8'h00, 32'h4);
    chk("b2b_dec2", dec, 4'b0001);
    tick();
    chk("b2b_dec_gone", dec, 4'b0000);

    // Sticky done, irq one cycle later, set beats clear.
    bus_op(1'b1, 1'b0, 8'h0B, 32'h1);
    done_in = 4'b0001; tick(); done_in = 4'b0000;
    chk("sticky_irq_not_yet", irq, 1'b0);
    tick();
    chk("sticky_irq", irq, 1'b1);
    bus_op(1'b0, 1'b1, 8'h0A, 32'h0);
    chk("sticky_status", bus.avs_readdata, 32'h1);
    bus_op(1'b0, 1'b1, 8'hE2, 32'h0);
    chk("sticky_pend", bus.avs_readdata, 32'h1);
    done_in = 4'b0001;
    bus_op(1'b1, 1'b0, 8'h0A, 32'h1);
    done_in = 4'b0000;
    bus_op(1'b0, 1'b1, 8'h0A, 32'h0);
    chk("set_beats_clr", bus.avs_readdata, 32'h1);
    bus_op(1'b1, 1'b0, 8'h0A, 32'h1);
    chk("w1c_irq_lag", irq, 1'b1);
    tick();
    chk("w1c_irq_low", irq, 1'b0);
    error_in[4:0] = 5'd5;
    bus_op(1'b0, 1'b1, 8'h0A, 32'h0);
    chk("err_live", bus.avs_readdata, 32'h0000_0500);
    error_in = '0;
    bus_op(1'b0, 1'b1, 8'h0A, 32'h0);
    chk("err_sticky", bus.avs_readdata, 32'h2);
    chk("err_no_irq", irq, 1'b0);

    // ABS_POS readback and readdata hold.
    abs_position[127:96] = -32'sd5;
    bus_op(1'b0, 1'b1, 8'h69, 32'h0);
    chk("abspos_valid", bus.avs_readdatavalid, 1'b1);
    chk("abspos_data", bus.avs_readdata, 32'hFFFF_FFFB);
    tick();
    chk("abspos_valid_drop", bus.avs_readdatavalid, 1'b0);
    chk("abspos_hold", bus.avs_readdata, 32'hFFFF_FFFB);

    // Shadow readback of MODE.
    bus_op(1'b1, 1'b0, 8'h01, 32'h3);
    bus_op(1'b0, 1'b1, 8'h01, 32'h0);
    chk("mode_active", bus.avs_readdata, 32'h0);
    bus_op(1'b1, 1'b0, 8'h0C, 32'h1);
    bus_op(1'b0, 1'b1, 8'h01, 32'h0);
    chk("mode_shadow", bus.avs_readdata, 32'h3);
    chk("mode_out", move_mode[4:0], 5'd0);

    // Reset in the cycle a stop pulse and a readdatavalid are high.
    bus_op(1'b1, 1'b1, 8'h00, 32'h2);
    chk("rst_mid_stop", stop, 4'b0001);
    chk("rst_mid_rvalid", bus.avs_readdatavalid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outs", {31'd0, outs_any()}, 32'd0);
    chk("rst_mid_rvalid0", bus.avs_readdatavalid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst_after_outs", {31'd0, outs_any()}, 32'd0);

    // Directed table from the fresh reset state.
    for (int i = 0; i < 23; i++) begin
      bus_op(tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].wd);
      if (tbl[i].rd) begin
        chk($sformatf("tbl%0d_valid", i), bus.avs_readdatavalid, 1'b1);
        chk($sformatf("tbl%0d_data", i), bus.avs_readdata, tbl[i].exp);
      end else begin
        chk($sformatf("tbl%0d_novalid", i), bus.avs_readdatavalid, 1'b0);
      end
    end
    chk("tbl_cfg", {enable, opt_level, set_dir}, {4'b0010, 4'b0010, 4'b0010});

    // Randomized traffic against the model.
    do_reset();
    m_reset();
    last_rd = 32'h0;
    for (int n = 0; n < 600; n++) begin
      int op, c;
      logic [4:0] o;
      op = $urandom_range(0, 3);
      c  = $urandom_range(0, 7);
      if (c == 7) o = 5'($urandom_range(0, 3));
      else if ($urandom_range(0, 15) == 0) o = 5'h1F;
      else o = 5'($urandom_range(0, 13));
      addr  = {3'(c), o};
      wd    = $urandom;
      do_wr = (op == 1) || (op == 3);
      do_rd = (op == 2) || (op == 3);
      done_in  = ($urandom_range(0, 5) == 0) ? NCH'($urandom) : '0;
      limit_in = NCH'($urandom);
      for (int k = 0; k < NCH; k++) begin
        error_in[5*k +: 5] = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
        abs_position[32*k +: 32] = $urandom;
      end
      bus.avs_write = do_wr; bus.avs_read = do_rd;
      bus.avs_address = addr; bus.avs_writedata = wd;
      exp_rd    = m_read(addr);
      pend_prev = m_pend();
      e_start = '0; e_stop = '0; e_dec = '0; e_abs = '0;
      tick();
      if (do_wr) m_write(addr, wd);
      for (int k = 0; k < NCH; k++) begin
        if (done_in[k]) m_done[k] = 1'b1;
        if (error_in[5*k +: 5] != 5'd0) m_err[k] = 1'b1;
      end
      if (do_rd) last_rd = exp_rd;
      chk($sformatf("rnd%0d_rvalid", n), bus.avs_readdatavalid, do_rd);
      chk($sformatf("rnd%0d_rdata", n), bus.avs_readdata, last_rd);
      chk($sformatf("rnd%0d_irq", n), irq, |pend_prev);
      m_check_outputs(n);
    end
    clear_inputs();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
